// File: rtl/cordic_shift_sequencer.sv
// CORDIC iteration sequencer: holds the working x/y/z, walks the per-mode shift
// schedule and hands operands plus arithmetic-shifted cross terms to the calculators.
module cordic_shift_sequencer #(
   parameter int WIDTH      = 32,
   parameter int ITERATIONS = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   input  logic [WIDTH-1:0] x_next,
   input  logic [WIDTH-1:0] y_next,
   input  logic [WIDTH-1:0] z_next,
   output logic [WIDTH-1:0] x_cur,
   output logic [WIDTH-1:0] y_cur,
   output logic [WIDTH-1:0] angle,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] x_shift,
   output logic [WIDTH-1:0] y_shift,
   output logic [5:0]       iter,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] CIRCULAR   = 2'b00;
   localparam logic [1:0] LINEAR     = 2'b01;
   localparam logic [1:0] HYPERBOLIC = 2'b10;

   localparam logic [5:0] LAST_CL  = 6'(ITERATIONS - 1);
   localparam logic [5:0] LAST_HYP = 6'(ITERATIONS);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [1:0]       mode_q, mode_d;
   logic [5:0]       iter_q, iter_d;
   logic             rep_q, rep_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       mode_sel;

   // Shift amounts at or beyond the word width collapse to pure sign fill.
   function automatic logic [WIDTH-1:0] shift_ar(input logic [WIDTH-1:0] v,
                                                 input logic [5:0]       sh);
      logic signed [WIDTH-1:0] sv;
      sv = signed'(v);
      if (int'(sh) >= WIDTH) return {WIDTH{v[WIDTH-1]}};
      return sv >>> sh;
   endfunction

   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      case (m)
         CIRCULAR:   return CIRCULAR;
         HYPERBOLIC: return HYPERBOLIC;
         default:    return LINEAR;
      endcase
   endfunction

   function automatic logic is_repeat(input logic [5:0] it);
      return (it == 6'd4) || (it == 6'd13) || (it == 6'd40);
   endfunction

   assign mode_sel = norm_mode(mode_in);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      mode_d  = mode_q;
      iter_d  = iter_q;
      rep_d   = rep_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = x_in;
               y_d     = y_in;
               z_d     = z_in;
               mode_d  = mode_sel;
               iter_d  = (mode_sel == HYPERBOLIC) ? 6'd1 : 6'd0;
               rep_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            x_d     = x_next;
            y_d     = y_next;
            z_d     = z_next;
            state_d = S_ISSUE;
            if (mode_q == HYPERBOLIC) begin
               if (iter_q == LAST_HYP) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (is_repeat(iter_q) && !rep_q) begin
                  rep_d = 1'b1;
               end else begin
                  iter_d = iter_q + 6'd1;
                  rep_d  = 1'b0;
               end
            end else if (iter_q == LAST_CL) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               iter_d = iter_q + 6'd1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         mode_q  <= CIRCULAR;
         iter_q  <= '0;
         rep_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         mode_q  <= mode_d;
         iter_q  <= iter_d;
         rep_q   <= rep_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x_cur   = x_q;
   assign y_cur   = y_q;
   assign angle   = z_q;
   assign mode    = mode_q;
   assign iter    = iter_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign x_shift = shift_ar(x_q, iter_q);
   assign y_shift = shift_ar(y_q, iter_q);

endmodule

// File: tb/tb_cordic_shift_sequencer.sv
// Scoreboard bench for cordic_shift_sequencer: stimulus queues expected steps/runs,
// a negedge monitor pops and compares whenever the sequencer presents a step or done.
module tb_cordic_shift_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start;
   logic [1:0]  mode_in;
   logic [31:0] x_in, y_in, z_in, x_next, y_next, z_next;
   logic [31:0] x_cur, y_cur, angle, x_shift, y_shift;
   logic [1:0]  mode;
   logic [5:0]  iter;
   logic        busy, done;

   logic        start2;
   logic [1:0]  mode_in2;
   logic [31:0] x_in2, y_in2, z_in2, x_next2, y_next2, z_next2;
   logic [31:0] x_cur2, y_cur2, angle2, x_shift2, y_shift2;
   logic [1:0]  mode2;
   logic [5:0]  iter2;
   logic        busy2, done2;

   cordic_shift_sequencer #(.WIDTH(32), .ITERATIONS(16)) dut (
      .clock(clk), .reset(rst), .start(start), .mode_in(mode_in),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .x_next(x_next), .y_next(y_next), .z_next(z_next),
      .x_cur(x_cur), .y_cur(y_cur), .angle(angle), .mode(mode),
      .x_shift(x_shift), .y_shift(y_shift), .iter(iter), .busy(busy), .done(done));

   cordic_shift_sequencer #(.WIDTH(32), .ITERATIONS(41)) dut2 (
      .clock(clk), .reset(rst), .start(start2), .mode_in(mode_in2),
      .x_in(x_in2), .y_in(y_in2), .z_in(z_in2),
      .x_next(x_next2), .y_next(y_next2), .z_next(z_next2),
      .x_cur(x_cur2), .y_cur(y_cur2), .angle(angle2), .mode(mode2),
      .x_shift(x_shift2), .y_shift(y_shift2), .iter(iter2), .busy(busy2), .done(done2));

   assign x_next2 = x_cur2;
   assign y_next2 = y_cur2;
   assign z_next2 = angle2;

   // Registered circular micro-rotation stage; angle unit is pi = 2^31.
   logic        use_calc;
   logic [31:0] cx, cy, cz;
   logic [31:0] atan_tab [0:63];
   always @(posedge clk) begin
      if (angle[31] == 1'b0) begin
         cx <= x_cur - y_shift;
         cy <= y_cur + x_shift;
         cz <= angle - atan_tab[iter];
      end else begin
         cx <= x_cur + y_shift;
         cy <= y_cur - x_shift;
         cz <= angle + atan_tab[iter];
      end
   end
   assign x_next = use_calc ? cx : x_cur;
   assign y_next = use_calc ? cy : y_cur;
   assign z_next = use_calc ? cz : angle;

   typedef struct { logic [5:0] it; logic chk; logic [31:0] xs; logic [31:0] ys; } step_t;
   typedef struct { logic [31:0] x; logic [31:0] y; logic [31:0] z; logic [1:0] m;
                    int lat; int tol; logic zchk; } run_t;
   typedef struct { logic [5:0] it; logic [31:0] xs; logic [31:0] ys; } probe_t;

   step_t  sq[$];
   run_t   rq[$];
   probe_t pq[$];
   int checks = 0;
   int errors = 0;
   int hyp_seq [18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                          input int tol);
      int d;
      checks++;
      d = int'(signed'(act)) - int'(signed'(exp));
      if (d < 0) d = -d;
      if ($isunknown(act) || d > tol) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h +/-%0d", name, act, exp, tol);
      end
   endtask

   task automatic push_step(input int it, input logic c, input logic [31:0] xs,
                            input logic [31:0] ys);
      step_t s;
      s.it = 6'(it); s.chk = c; s.xs = xs; s.ys = ys;
      sq.push_back(s);
   endtask

   task automatic push_run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input logic [1:0] m, input int lat, input int tol, input logic zc);
      run_t r;
      r.x = x; r.y = y; r.z = z; r.m = m; r.lat = lat; r.tol = tol; r.zchk = zc;
      rq.push_back(r);
   endtask

   task automatic push_probe(input int it, input logic [31:0] xs, input logic [31:0] ys);
      probe_t p;
      p.it = 6'(it); p.xs = xs; p.ys = ys;
      pq.push_back(p);
   endtask

   task automatic issue(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z);
      @(posedge clk); #1;
      mode_in = m; x_in = x; y_in = y; z_in = z; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string name);
      int n = 0;
      while (done !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, maxc);
      end
   endtask

   // Monitor: each ISSUE cycle of a run pops one step, each done pops one run.
   bit mon_in_run = 0;
   int mon_cyc = 0;
   bit mon_expect_idle = 0;
   initial begin : monitor
      step_t s;
      run_t  r;
      forever begin
         @(negedge clk);
         if (mon_expect_idle) begin
            chk("busy_after_done", {31'b0, busy}, 32'd0);
            mon_expect_idle = 0;
         end
         if (busy === 1'b1) begin
            if (!mon_in_run) begin mon_in_run = 1; mon_cyc = 0; end
            else mon_cyc++;
            if (done === 1'b1) begin
               mon_expect_idle = 1;
               if (rq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done actual=done required=no_run_pending");
               end else begin
                  r = rq.pop_front();
                  if (r.tol > 0) begin
                     chk_tol("final_x", x_cur, r.x, r.tol);
                     chk_tol("final_y", y_cur, r.y, r.tol);
                  end else begin
                     chk("final_x", x_cur, r.x);
                     chk("final_y", y_cur, r.y);
                  end
                  if (r.zchk) chk("final_z", angle, r.z);
                  chk("run_mode", {30'b0, mode}, {30'b0, r.m});
                  chk("latency", 32'(mon_cyc), 32'(r.lat));
               end
            end else if (mon_cyc % 2 == 0) begin
               if (sq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_step actual=iter%0d required=no_step", iter);
               end else begin
                  s = sq.pop_front();
                  chk("step_iter", {26'b0, iter}, {26'b0, s.it});
                  if (s.chk) begin
                     chk("x_shift", x_shift, s.xs);
                     chk("y_shift", y_shift, s.ys);
                  end
               end
            end
         end else begin
            mon_in_run = 0;
         end
      end
   end

   initial begin : monitor2
      probe_t p;
      forever begin
         @(negedge clk);
         if (busy2 === 1'b1 && pq.size() > 0 && iter2 == pq[0].it) begin
            p = pq.pop_front();
            chk("wide_x_shift", x_shift2, p.xs);
            chk("wide_y_shift", y_shift2, p.ys);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      for (int i = 0; i < 64; i++)
         atan_tab[i] = 32'($rtoi($atan(2.0 ** (-i)) / 3.14159265358979 * 2147483648.0));
      rst = 1'b1; start = 1'b0; mode_in = 2'b00; x_in = '0; y_in = '0; z_in = '0;
      start2 = 1'b0; mode_in2 = 2'b00; x_in2 = '0; y_in2 = '0; z_in2 = '0;
      use_calc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x_cur", x_cur, 32'd0);
      chk("rst_y_cur", y_cur, 32'd0);
      chk("rst_angle", angle, 32'd0);
      chk("rst_iter", {26'b0, iter}, 32'd0);
      chk("rst_mode", {30'b0, mode}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;

      // Circular echo run
      for (int i = 0; i < 16; i++) push_step(i, 1'b1, 32'h4000_0000 >> i, 32'd0);
      push_run(32'h4000_0000, 32'd0, 32'd0, 2'b00, 32, 0, 1'b1);
      issue(2'b00, 32'h4000_0000, 32'd0, 32'd0);
      wait_done(60, "circ");
      @(posedge clk); #1;

      // Hyperbolic echo run with repeats at 4 and 13
      for (int i = 0; i < 18; i++)
         push_step(hyp_seq[i], 1'b1, 32'h4000_0000 >> hyp_seq[i], 32'd0);
      push_run(32'h4000_0000, 32'd0, 32'h0000_0100, 2'b10, 36, 0, 1'b1);
      issue(2'b10, 32'h4000_0000, 32'd0, 32'h0000_0100);
      wait_done(60, "hyp");
      @(posedge clk); #1;

      // Linear run with a stray start mid-run and one in the DONE cycle
      for (int i = 0; i < 16; i++)
         push_step(i, 1'b1, 32'h1234_5678 >> i, ~(32'h0FFF_FFFF >> i));
      push_run(32'h1234_5678, 32'hF000_0000, 32'h0000_00AB, 2'b01, 32, 0, 1'b1);
      issue(2'b01, 32'h1234_5678, 32'hF000_0000, 32'h0000_00AB);
      repeat (5) @(posedge clk);
      #1;
      x_in = 32'hDEAD_BEEF; mode_in = 2'b10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, "lin");
      for (int i = 0; i < 16; i++) push_step(i, 1'b0, 32'd0, 32'd0);
      push_run(32'hCAFE_0001, 32'h0000_0055, 32'h8000_0000, 2'b01, 32, 0, 1'b1);
      mode_in = 2'b11; x_in = 32'hCAFE_0001; y_in = 32'h0000_0055; z_in = 32'h8000_0000;
      start = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, "restart");
      @(posedge clk); #1;

      // Reset during CAPTURE of step 7, then a full run
      for (int i = 0; i < 8; i++) push_step(i, 1'b1, 32'h4000_0000 >> i, 32'd0);
      issue(2'b00, 32'h4000_0000, 32'd0, 32'd0);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_x_cur", x_cur, 32'd0);
      chk("abort_x_shift", x_shift, 32'd0);
      chk("abort_iter", {26'b0, iter}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 16; i++) push_step(i, 1'b1, 32'h4000_0000 >> i, 32'd0);
      push_run(32'h4000_0000, 32'd0, 32'd0, 2'b00, 32, 0, 1'b1);
      issue(2'b00, 32'h4000_0000, 32'd0, 32'd0);
      wait_done(60, "post_reset");
      @(posedge clk); #1;

      // Real micro-rotations: x=1/K, z=pi/6 -> (cos30, sin30) in Q2.30
      use_calc = 1'b1;
      for (int i = 0; i < 16; i++) push_step(i, 1'b0, 32'd0, 32'd0);
      push_run(32'd929887697, 32'd536870912, 32'd0, 2'b00, 32, 1 << 20, 1'b0);
      issue(2'b00, 32'h26DD_3B6A, 32'd0, 32'h1555_5555);
      wait_done(60, "rotate");
      @(posedge clk); #1;
      use_calc = 1'b0;

      // Wide-iteration instance: shifts at and beyond the word width
      for (int pass = 0; pass < 2; pass++) begin
         push_probe(31, 32'd0, (pass == 0) ? 32'hFFFF_FFFF : 32'd0);
         push_probe(40, 32'd0, (pass == 0) ? 32'hFFFF_FFFF : 32'd0);
         @(posedge clk); #1;
         mode_in2 = 2'b10; x_in2 = 32'd0; z_in2 = 32'd0;
         y_in2 = (pass == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         start2 = 1'b1;
         @(posedge clk); #1;
         start2 = 1'b0;
         n = 0;
         while (done2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("wide_latency", 32'(n), 32'd89);
         chk("wide_final_y", y_cur2, (pass == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
         chk("wide_mode", {30'b0, mode2}, 32'd2);
         @(posedge clk); #1;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("step_queue_empty", 32'(sq.size()), 32'd0);
      chk("run_queue_empty", 32'(rq.size()), 32'd0);
      chk("probe_queue_empty", 32'(pq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
